uart_rx: RTL
============

Name: uart_rx

Overview:
Serial UART receiver; downstream stage that consumes the line driven by uart_tx.
- Frame format: 8N1-style, 1 start bit, BUS_WIDTH data bits LSB first, 1 stop bit, no parity.
- Bit timing matches uart_tx: a bit period is BIT_CLKS = CLK_FREQ/UART_SPEED + 1 clocks.
- Delivers each received word as a parallel word with a one-cycle valid strobe to the SoC-side consumer (register block or RX FIFO).

Parameters:
- BUS_WIDTH, 8, data bits per frame.
- UART_SPEED, 115200, baud rate.
- CLK_FREQ, 50000000, clk frequency in Hz.
- localparams: PULSE_WIDTH = CLK_FREQ/UART_SPEED; BIT_CLKS = PULSE_WIDTH+1; HALF_BIT = BIT_CLKS/2 (integer division); CNT_WIDTH = $clog2(BIT_CLKS); DATA_CNT_WIDTH = $clog2(BUS_WIDTH).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset. One clock domain; reset is asynchronous assert, active-low.
- rx  input  1  asynchronous serial line, idles high.
- data  output  BUS_WIDTH  last good received word; held until the next good frame.
- valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except ST_IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): data=0, valid=0, frame_err=0, busy=0, state=ST_IDLE, both sync flops=1, counters=0. Asserting reset mid-frame aborts the frame with no valid or frame_err pulse.
- Synchroniser: rx passes through 2 flops to give rx_s. Start detect is rx_s==0 while in ST_IDLE, giving 2 cycles of input latency.
- Bit counter: restarts at 0 on every state entry and on every bit boundary. It does not free-run.
- ST_IDLE: when rx_s==0, clear the counter and go to ST_START.
- ST_START: at cnt==HALF_BIT-1, sample rx_s.
  - If 1: glitch; return to ST_IDLE with no output.
  - If 0: clear cnt and the data counter; go to ST_DATA. Sampling point is now mid-bit.
- ST_DATA: at cnt==BIT_CLKS-1, sample rx_s into shift[data_cnt] (LSB first).
  - When data_cnt==BUS_WIDTH-1, go to ST_STOP; otherwise increment data_cnt.
- ST_STOP: at cnt==BIT_CLKS-1, sample rx_s.
  - If 1: data<=shift and valid=1 for the next cycle only; go to ST_IDLE immediately. This allows a back-to-back start edge in the second half of the stop bit.
  - If 0: frame_err=1 for one cycle; data is unchanged; go to ST_BREAK.
- ST_BREAK: stay until rx_s==1, then go to ST_IDLE. A held-low break line produces exactly one frame_err.
- valid and frame_err are never high together. No handshake or backpressure exists: the consumer must capture data on valid. A new good frame overwrites data.
- Latency: valid rises 2 + HALF_BIT + (BUS_WIDTH+1)*BIT_CLKS + 1 cycles after the rx falling edge, within ±1 cycle.
- Timing tolerance: accepts an rx baud mismatch up to ±4% relative to BIT_CLKS.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: every sample (start, data, stop) is the majority of rx_s at cnt = S-1, S, S+1 around the nominal sample point S. This adds a 2-bit sample register and a 3-input vote.
- Undefined: a single sample is taken at S.
- Frame timing, ports and latency are identical in both builds; with the macro defined the decision is registered at S+1.

Decomposition:
- Package uart_pkg: the state enum {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} and a function computing BIT_CLKS from CLK_FREQ/UART_SPEED, shared with uart_tx for future reuse.
- Sub-module uart_rx_sync: the 2-flop synchroniser with async active-low reset to 1, output rx_s.
- All other logic (FSM, counters, shift register) lives in uart_rx.

Test Plan:
All scenarios use CLK_FREQ=1000000 and UART_SPEED=100000, giving BIT_CLKS=11 and HALF_BIT=5.
- Frame 0xA5 with good stop bit -> data=0xA5; valid pulses once, 1 cycle wide, about 108 cycles after the falling edge; frame_err stays 0.
- Two back-to-back frames 0x3C then 0xC3 (next start immediately after stop) -> two valid pulses; data=0x3C then 0xC3.
- 3-cycle low glitch on idle line -> returns to ST_IDLE; no valid; busy high for at most 8 cycles.
- Frame 0x55 with stop bit low, line then held low for 50 bit times -> exactly one frame_err pulse; data keeps its previous value; busy drops after rx returns high.
- rst_n pulsed low during data bit 4 of frame 0xFF -> outputs cleared immediately; no pulse; the next clean frame 0x81 is received correctly.
- With UART_RX_MAJORITY_EN defined: 1-cycle low glitch injected at the mid-sample of data bit 2 of 0xFF -> data=0xFF. Without the macro, the same stimulus gives data=0xFB.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
// Kept separate so uart_tx and uart_rx derive bit timing identically.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Clocks per bit: the pulse width plus one, matching the transmitter.
    function automatic int calc_bit_clks(input int clk_freq, input int uart_speed);
        return clk_freq / uart_speed + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser bringing the asynchronous rx line into the clk domain.
// Both flops reset to 1 so the line reads idle straight out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, BUS_WIDTH data bits LSB first, 1 stop bit.
// Build option UART_RX_MAJORITY_EN: each bit decision becomes a 3-sample
// majority vote around the nominal sample point; the whole frame schedule is
// shifted one clock later so the vote window is centred on that point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int UART_SPEED = 115200,
    parameter int CLK_FREQ   = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int PULSE_WIDTH    = CLK_FREQ / UART_SPEED;
    localparam int BIT_CLKS       = calc_bit_clks(CLK_FREQ, UART_SPEED);
    localparam int HALF_BIT       = BIT_CLKS / 2;
    localparam int CNT_WIDTH      = $clog2(BIT_CLKS);
    localparam int DATA_CNT_WIDTH = $clog2(BUS_WIDTH);

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_DELAY = 1;
`else
    localparam int SAMPLE_DELAY = 0;
`endif

    // Start bit is checked near its middle; every later decision lands one
    // full bit period after the previous one, i.e. on the last count of a bit.
    localparam logic [CNT_WIDTH-1:0] START_LAST =
        CNT_WIDTH'(HALF_BIT - 1 + SAMPLE_DELAY);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(PULSE_WIDTH);
    localparam logic [DATA_CNT_WIDTH-1:0] DATA_LAST = DATA_CNT_WIDTH'(BUS_WIDTH - 1);

    logic                      rx_s;
    logic                      sample;
    state_t                    state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [DATA_CNT_WIDTH-1:0] data_cnt;
    logic [BUS_WIDTH-1:0]      shift;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous synchronised samples for the 3-way vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    // Frame FSM with bit counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            data_cnt  <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == START_LAST) begin
                        cnt <= '0;
                        if (sample) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_DATA;
                            data_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt             <= '0;
                        shift[data_cnt] <= sample;
                        if (data_cnt == DATA_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            data_cnt <= data_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (sample) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
